// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source and the pwm_capture block.
// The capture block attaches through the slave modport; the source/observer attaches through master.
interface pwm_capture_if #(
   parameter int CNT_W = 16
);
   logic             pwm_in;
   logic [CNT_W-1:0] high_time;
   logic [CNT_W-1:0] period;
   logic             meas_valid;
   logic             stuck_high;
   logic             stuck_low;

   modport master (
      output pwm_in,
      input  high_time, period, meas_valid, stuck_high, stuck_low
   );

   modport slave (
      input  pwm_in,
      output high_time, period, meas_valid, stuck_high, stuck_low
   );
endinterface

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input and flags stuck levels.
// Optional glitch filter enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic            clk,
   input  logic            rst,
   pwm_capture_if.slave    bus
);

   typedef enum logic [1:0] {ST_WAIT, ST_HIGH, ST_LOW} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   generate
      if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_badParam
         $error("pwm_capture: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_syncOut;
   logic                   w_s;
   logic                   r_sD;
   logic                   w_rise;
   logic                   w_fall;

   state_t           r_state, w_stateNext;
   logic [CNT_W-1:0] r_hCnt, w_hNext;
   logic [CNT_W-1:0] r_pCnt, w_pNext;
   logic [CNT_W-1:0] w_hInc, w_pInc;
   logic             w_timeout;
   logic [CNT_W-1:0] r_highTime, w_highTimeNext;
   logic [CNT_W-1:0] r_period, w_periodNext;
   logic             r_measValid, w_measValidNext;
   logic             r_stuckHigh, w_stuckHighNext;
   logic             r_stuckLow, w_stuckLowNext;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pwm_in};
      end
   end

   assign w_syncOut = r_sync[SYNC_STAGES-1];

`ifdef PWM_CAP_FILTER_EN
   localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   logic            r_filtS;
   logic [FC_W-1:0] r_filtCnt;

   // s follows the synchronized input only once it has disagreed for FILT_LEN straight cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         r_filtS   <= 1'b0;
         r_filtCnt <= '0;
      end else if (w_syncOut != r_filtS) begin
         if (r_filtCnt == FC_W'(FILT_LEN - 1)) begin
            r_filtS   <= w_syncOut;
            r_filtCnt <= '0;
         end else begin
            r_filtCnt <= r_filtCnt + FC_W'(1);
         end
      end else begin
         r_filtCnt <= '0;
      end
   end

   assign w_s = r_filtS;
`else
   assign w_s = w_syncOut;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sD <= 1'b0;
      end else begin
         r_sD <= w_s;
      end
   end

   assign w_rise    = w_s & ~r_sD;
   assign w_fall    = ~w_s & r_sD;
   assign w_hInc    = (r_hCnt == CNT_MAX) ? r_hCnt : r_hCnt + CNT_ONE;
   assign w_pInc    = (r_pCnt == CNT_MAX) ? r_pCnt : r_pCnt + CNT_ONE;
   assign w_timeout = (r_pCnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_WAIT;
         r_hCnt      <= '0;
         r_pCnt      <= '0;
         r_highTime  <= '0;
         r_period    <= '0;
         r_measValid <= 1'b0;
         r_stuckHigh <= 1'b0;
         r_stuckLow  <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_hCnt      <= w_hNext;
         r_pCnt      <= w_pNext;
         r_highTime  <= w_highTimeNext;
         r_period    <= w_periodNext;
         r_measValid <= w_measValidNext;
         r_stuckHigh <= w_stuckHighNext;
         r_stuckLow  <= w_stuckLowNext;
      end
   end

   // Edges take priority over the timeout, so a period of exactly the counter range is still reported
   always_comb begin
      w_stateNext     = r_state;
      w_hNext         = r_hCnt;
      w_pNext         = r_pCnt;
      w_highTimeNext  = r_highTime;
      w_periodNext    = r_period;
      w_measValidNext = 1'b0;
      w_stuckHighNext = r_stuckHigh;
      w_stuckLowNext  = r_stuckLow;
      case (r_state)
         ST_WAIT: begin
            if (w_rise) begin
               w_stateNext     = ST_HIGH;
               w_hNext         = CNT_ONE;
               w_pNext         = CNT_ONE;
               w_stuckHighNext = 1'b0;
               w_stuckLowNext  = 1'b0;
            end
         end
         ST_HIGH: begin
            if (w_fall) begin
               w_stateNext = ST_LOW;
               w_pNext     = w_pInc;
            end else if (w_timeout) begin
               w_stateNext     = ST_WAIT;
               w_stuckHighNext = 1'b1;
               w_stuckLowNext  = 1'b0;
            end else begin
               w_hNext = w_hInc;
               w_pNext = w_pInc;
            end
         end
         ST_LOW: begin
            if (w_rise) begin
               w_stateNext     = ST_HIGH;
               w_highTimeNext  = r_hCnt;
               w_periodNext    = r_pCnt;
               w_measValidNext = 1'b1;
               w_hNext         = CNT_ONE;
               w_pNext         = CNT_ONE;
            end else if (w_timeout) begin
               w_stateNext     = ST_WAIT;
               w_stuckLowNext  = 1'b1;
               w_stuckHighNext = 1'b0;
            end else begin
               w_pNext = w_pInc;
            end
         end
         default: begin
            w_stateNext = ST_WAIT;
         end
      endcase
   end

   assign bus.high_time  = r_highTime;
   assign bus.period     = r_period;
   assign bus.meas_valid = r_measValid;
   assign bus.stuck_high = r_stuckHigh;
   assign bus.stuck_low  = r_stuckLow;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: vector table, directed corner sequences and random waveforms
// compared every cycle against a period-level reference model (PWM_CAP_FILTER_EN selects filter build).
module tb_pwm_capture;

   localparam int CNT_W       = 8;
   localparam int SYNC_STAGES = 2;
   localparam int FILT_LEN    = 3;
   localparam int MAXV        = (1 << CNT_W) - 1;
`ifdef PWM_CAP_FILTER_EN
   localparam int DEPTH     = SYNC_STAGES + 2;
   localparam int LAT_EDGES = SYNC_STAGES + 1 + FILT_LEN;
`else
   localparam int DEPTH     = SYNC_STAGES + 1;
   localparam int LAT_EDGES = SYNC_STAGES + 1;
`endif
   localparam int FLUSH = DEPTH + FILT_LEN + 4;

   typedef struct {
      int hi;
      int lo;
      int expHt;
      int expPer;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   cycleNum = 0;
   int   validCount = 0;
   int   lastHt = 0;
   int   lastPer = 0;
   bit   qHist[$];
   vec_t vecs[$];

   // Reference model state, in terms of rise/fall times rather than counters
   bit mPrev, mRun, mFl;
   int mFcnt, mN, mStart, mFall;
   bit expValid, expSh, expSl;
   int expHt, expPer;

   pwm_capture_if #(.CNT_W(CNT_W)) bus ();

   pwm_capture #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int satMin(input int v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   function automatic void modelReset();
      mPrev = 0; mRun = 0; mFl = 0; mFcnt = 0; mN = 0; mStart = 0; mFall = -1;
      expValid = 0; expSh = 0; expSl = 0; expHt = 0; expPer = 0;
   endfunction

   function automatic void modelStep(input bit x);
      bit lvl, rise, fall;
      int el;
`ifdef PWM_CAP_FILTER_EN
      if (x != mFl) begin
         mFcnt++;
         if (mFcnt == FILT_LEN) begin
            mFl = x;
            mFcnt = 0;
         end
      end else begin
         mFcnt = 0;
      end
      lvl = mFl;
`else
      lvl = x;
`endif
      rise = lvl && !mPrev;
      fall = !lvl && mPrev;
      mPrev = lvl;
      expValid = 0;
      if (!mRun) begin
         if (rise) begin
            mRun = 1; mStart = mN; mFall = -1; expSh = 0; expSl = 0;
         end
      end else begin
         el = mN - mStart;
         if (rise) begin
            expValid = 1;
            expHt  = satMin(mFall - mStart);
            expPer = satMin(el);
            mStart = mN;
            mFall  = -1;
         end else if (fall) begin
            mFall = mN;
         end else if (el >= MAXV) begin
            if (mFall < 0) begin
               expSh = 1; expSl = 0;
            end else begin
               expSl = 1; expSh = 0;
            end
            mRun = 0;
         end
      end
      mN++;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic int packOut(input bit v, input bit sh, input bit sl, input int ht, input int per);
      logic [CNT_W-1:0] h, p;
      h = CNT_W'(ht);
      p = CNT_W'(per);
      return int'({v, sh, sl, h, p});
   endfunction

   task automatic applyStimulus(input bit pinVal);
      bit x;
      bus.pwm_in = pinVal;
      @(posedge clk);
      #1;
      qHist.push_back(pinVal);
      x = qHist.pop_front();
      modelStep(x);
      checkOutput($sformatf("cycle %0d {valid,stuckH,stuckL,high_time,period}", cycleNum),
                  packOut(bus.meas_valid, bus.stuck_high, bus.stuck_low,
                          int'(bus.high_time), int'(bus.period)),
                  packOut(expValid, expSh, expSl, expHt, expPer));
      if (bus.meas_valid) begin
         validCount++;
         lastHt  = int'(bus.high_time);
         lastPer = int'(bus.period);
      end
      cycleNum++;
   endtask

   task automatic holdLevel(input bit v, input int n);
      for (int i = 0; i < n; i++) applyStimulus(v);
   endtask

   task automatic wave(input int hi, input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         holdLevel(1'b1, hi);
         holdLevel(1'b0, lo);
      end
   endtask

   task automatic doReset(input int n);
      rst = 1'b1;
      bus.pwm_in = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      checkOutput("reset outputs",
                  packOut(bus.meas_valid, bus.stuck_high, bus.stuck_low,
                          int'(bus.high_time), int'(bus.period)), 0);
      rst = 1'b0;
      modelReset();
      qHist.delete();
      for (int i = 0; i < DEPTH - 1; i++) qHist.push_back(1'b0);
      lastHt = 0;
      lastPer = 0;
   endtask

   initial begin
      int vc0, lat;
      bit seen;

`ifdef PWM_CAP_FILTER_EN
      vecs.push_back('{4, 12, 4, 16});
      vecs.push_back('{10, 10, 10, 20});
      vecs.push_back('{8, 8, 8, 16});
      vecs.push_back('{3, 5, 3, 8});
      vecs.push_back('{5, 3, 5, 8});
`else
      vecs.push_back('{4, 12, 4, 16});
      vecs.push_back('{10, 10, 10, 20});
      vecs.push_back('{2, 18, 2, 20});
      vecs.push_back('{1, 1, 1, 2});
      vecs.push_back('{8, 8, 8, 16});
      vecs.push_back('{7, 3, 7, 10});
`endif

      bus.pwm_in = 1'b0;
      doReset(3);

      // Pin-to-valid latency on a steady 4/16 waveform
      holdLevel(1'b0, 5);
      wave(4, 12, 2);
      seen = 0;
      lat = 0;
      for (int e = 1; e <= 20 && !seen; e++) begin
         applyStimulus((e <= 4) ? 1'b1 : 1'b0);
         if (bus.meas_valid) begin
            seen = 1;
            lat = e;
         end
      end
      checkOutput("latency valid seen", int'(seen), 1);
      checkOutput("latency edges", lat, LAT_EDGES);
      checkOutput("steady high_time", lastHt, 4);
      checkOutput("steady period", lastPer, 16);
      holdLevel(1'b0, 16 - 4 - lat);

      // Vector table
      for (int i = 0; i < vecs.size(); i++) begin
         wave(vecs[i].hi, vecs[i].lo, 4);
         holdLevel(1'b0, FLUSH);
         checkOutput($sformatf("table %0d high_time", i), lastHt, vecs[i].expHt);
         checkOutput($sformatf("table %0d period", i), lastPer, vecs[i].expPer);
      end

      // Stuck low after a falling edge
      holdLevel(1'b0, MAXV + 20);
      checkOutput("stuck_low set", int'(bus.stuck_low), 1);
      checkOutput("stuck_high clear at low timeout", int'(bus.stuck_high), 0);

      // Stuck high: the rise starts from WAIT, so no valid may appear
      vc0 = validCount;
      holdLevel(1'b1, MAXV + 20);
      checkOutput("stuck_high set", int'(bus.stuck_high), 1);
      checkOutput("stuck_low cleared by rise", int'(bus.stuck_low), 0);
      checkOutput("no valid while stuck high", validCount - vc0, 0);

      // Recovery
      holdLevel(1'b0, 6);
      wave(3, 5, 3);
      holdLevel(1'b0, FLUSH);
      checkOutput("stuck_high cleared", int'(bus.stuck_high), 0);
      checkOutput("recovered high_time", lastHt, 3);
      checkOutput("recovered period", lastPer, 8);

`ifdef PWM_CAP_FILTER_EN
      // 2-cycle glitch inside the low phase must be ignored
      wave(8, 8, 3);
      holdLevel(1'b0, FLUSH);
      checkOutput("filter 8/8 high_time", lastHt, 8);
      checkOutput("filter 8/8 period", lastPer, 16);
      for (int i = 0; i < 4; i++) begin
         holdLevel(1'b1, 5);
         holdLevel(1'b0, 4);
         holdLevel(1'b1, 2);
         holdLevel(1'b0, 5);
      end
      holdLevel(1'b0, FLUSH);
      checkOutput("glitch high_time", lastHt, 5);
      checkOutput("glitch period", lastPer, 16);
`else
      wave(1, 1, 6);
      holdLevel(1'b0, FLUSH);
      checkOutput("min pulse high_time", lastHt, 1);
      checkOutput("min pulse period", lastPer, 2);
`endif

      // Reset mid-measurement discards the partial period
      wave(5, 5, 2);
      holdLevel(1'b1, 2);
      doReset(2);
      holdLevel(1'b0, 4);
      vc0 = validCount;
      wave(6, 4, 1);
      checkOutput("no valid after reset first period", validCount - vc0, 0);
      holdLevel(1'b1, 1);
      holdLevel(1'b0, FLUSH);
      checkOutput("post-reset high_time", lastHt, 6);
      checkOutput("post-reset period", lastPer, 10);

      // Randomized waveforms, checked cycle by cycle against the model
      for (int i = 0; i < 50; i++) begin
         case ($urandom_range(0, 9))
            0: holdLevel(1'($urandom_range(0, 1)), $urandom_range(MAXV - 5, MAXV + 10));
            1: for (int j = 0; j < 30; j++) applyStimulus(1'($urandom_range(0, 1)));
            default: wave($urandom_range(1, 25), $urandom_range(1, 25), $urandom_range(1, 3));
         endcase
      end
      holdLevel(1'b0, FLUSH);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
